// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-master SRAM arbiter.
package sram_arb_pkg;
  localparam int SRAM_ADDR_W      = 20;
  localparam int SRAM_DATA_W      = 16;
  localparam int SRAM_MAX_PENDING = 4;

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] address;
    logic [1:0]             byteenable;
    logic                   read;
    logic                   write;
    logic [SRAM_DATA_W-1:0] writedata;
  } sram_cmd_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between two Avalon-MM style masters, the arbiter and the SRAM controller.
interface sram_arbiter_if #(parameter int ADDR_W = 20, parameter int DATA_W = 16);
  logic [ADDR_W-1:0] m0_address,    m1_address;
  logic [1:0]        m0_byteenable, m1_byteenable;
  logic              m0_read,       m1_read;
  logic              m0_write,      m1_write;
  logic [DATA_W-1:0] m0_writedata,  m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata,   m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic [1:0]        s_byteenable;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_address, s_byteenable, s_read, s_write, s_writedata,
    input  s_readdata, s_readdatavalid
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_address, s_byteenable, s_read, s_write, s_writedata,
    output s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/sram_arb_id_fifo.sv
// Tracks which master owns each outstanding read; one-bit entries, in-order pop.
module sram_arb_id_fifo
  import sram_arb_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  master_id_t push_id,
  input  logic       pop,
  output master_id_t pop_id,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(MAX_PENDING);

  master_id_t     mem [MAX_PENDING];
  logic [PW:0]    wr_ptr, rd_ptr;

  // Extra pointer MSB separates full from empty; pointers wrap by overflow.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_id = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_id;
  end
endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of the SRAM controller with in-order read return steering.
// Define SRAM_ARB_FIXED_PRIORITY_EN for fixed m0-first priority instead of round-robin.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int MAX_PENDING = SRAM_MAX_PENDING
) (
  input  logic          clk,
  input  logic          reset_n,
  sram_arbiter_if.slave bus,
  output logic          rd_err
);
  sram_cmd_t [1:0]          cmd;
  sram_cmd_t                s_cmd;
  logic [1:0]               req, rd_only, elig, gnt;
  master_id_t               gnt_id, pop_id;
  logic                     full, empty, push, pop;
  logic [1:0]               rdv;
  logic [1:0][DATA_W-1:0]   rdata;

  // read+write together is a write
  always_comb begin
    cmd[0].address    = bus.m0_address;
    cmd[0].byteenable = bus.m0_byteenable;
    cmd[0].read       = bus.m0_read & ~bus.m0_write;
    cmd[0].write      = bus.m0_write;
    cmd[0].writedata  = bus.m0_writedata;
    cmd[1].address    = bus.m1_address;
    cmd[1].byteenable = bus.m1_byteenable;
    cmd[1].read       = bus.m1_read & ~bus.m1_write;
    cmd[1].write      = bus.m1_write;
    cmd[1].writedata  = bus.m1_writedata;
  end

  assign req     = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
  assign rd_only = {cmd[1].read, cmd[0].read};
  assign elig    = req & ~(rd_only & {2{full}});
  assign gnt_id  = gnt[1] ? M1 : M0;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt = '0;
    if (elig[0])      gnt = 2'b01;
    else if (elig[1]) gnt = 2'b10;
    if (!reset_n) gnt = '0;
  end
`else
  master_id_t last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  last <= M1;
    else if (|gnt) last <= gnt_id;
  end

  always_comb begin
    gnt = elig;
    if (&elig) gnt = (last == M0) ? 2'b10 : 2'b01;
    if (!reset_n) gnt = '0;
  end
`endif

  assign bus.m0_waitrequest = ~gnt[0];
  assign bus.m1_waitrequest = ~gnt[1];

  assign push = |(gnt & rd_only);
  assign pop  = bus.s_readdatavalid & ~empty;

  sram_arb_id_fifo #(.MAX_PENDING(MAX_PENDING)) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .push_id (gnt_id),
    .pop     (pop),
    .pop_id  (pop_id),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_cmd  <= '0;
      rdv    <= '0;
      rdata  <= '0;
      rd_err <= 1'b0;
    end else begin
      s_cmd  <= (|gnt) ? cmd[gnt_id] : '0;
      rdv    <= pop ? ((pop_id == M1) ? 2'b10 : 2'b01) : 2'b00;
      if (pop) rdata[pop_id] <= bus.s_readdata;
      // a response with nothing outstanding is dropped and flagged until reset
      rd_err <= rd_err | (bus.s_readdatavalid & empty);
    end
  end

  assign bus.s_address        = s_cmd.address;
  assign bus.s_byteenable     = s_cmd.byteenable;
  assign bus.s_read           = s_cmd.read;
  assign bus.s_write          = s_cmd.write;
  assign bus.s_writedata      = s_cmd.writedata;
  assign bus.m0_readdatavalid = rdv[0];
  assign bus.m1_readdatavalid = rdv[1];
  assign bus.m0_readdata      = rdata[0];
  assign bus.m1_readdata      = rdata[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus queue-based random traffic model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rd_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .MAX_PENDING(MAXP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .rd_err  (rd_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_read = 0; bus.m0_write = 0; bus.m0_writedata = '0;
    bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_read = 0; bus.m1_write = 0; bus.m1_writedata = '0;
    bus.s_readdata = '0; bus.s_readdatavalid = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 0;
    idle();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    bus.m0_read = 1; bus.m1_write = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_wait: got %b/%b want 1/1", bus.m0_waitrequest, bus.m1_waitrequest);
    end
    checks++;
    if (bus.s_read !== 1'b0 || bus.s_write !== 1'b0 || rd_err !== 1'b0) begin
      errors++; $display("FAIL reset_cmd: s_read=%b s_write=%b rd_err=%b want 0", bus.s_read, bus.s_write, rd_err);
    end
    checks++;
    if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL reset_rdv: got %b/%b want 0/0", bus.m0_readdatavalid, bus.m1_readdatavalid);
    end
    checks++;
    if (bus.m0_readdata !== 16'h0 || bus.m1_readdata !== 16'h0 || bus.s_address !== 20'h0) begin
      errors++; $display("FAIL reset_data: rd0=%h rd1=%h s_addr=%h want 0", bus.m0_readdata, bus.m1_readdata, bus.s_address);
    end
    idle();
    reset_n = 1;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    idle();
    bus.m0_write = 1; bus.m0_address = 20'h00010; bus.m0_writedata = 16'hBEEF; bus.m0_byteenable = 2'b11;
    #1;
    checks++;
    if (bus.m0_waitrequest !== 1'b0) begin
      errors++; $display("FAIL wr_grant: m0_waitrequest=%b want 0", bus.m0_waitrequest);
    end
    @(negedge clk);
    idle();
    checks++;
    if (bus.s_write !== 1'b1 || bus.s_read !== 1'b0 || bus.s_address !== 20'h00010 ||
        bus.s_writedata !== 16'hBEEF || bus.s_byteenable !== 2'b11) begin
      errors++; $display("FAIL wr_fwd: wr=%b rd=%b addr=%h data=%h be=%b want 1 0 00010 beef 11",
                         bus.s_write, bus.s_read, bus.s_address, bus.s_writedata, bus.s_byteenable);
    end
    @(negedge clk);
    checks++;
    if (bus.s_write !== 1'b0) begin
      errors++; $display("FAIL wr_oneshot: s_write=%b want 0", bus.s_write);
    end
  endtask

  task automatic test_interleave();
    logic [19:0] ad [3];
    logic [15:0] dv [3];
    int          who [3];
    logic [15:0] got;
    ad = '{20'h1, 20'h2, 20'h3};
    dv = '{16'h1111, 16'h2222, 16'h3333};
    who = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      if (who[i] == 0) begin bus.m0_read = 1; bus.m0_address = ad[i]; end
      else             begin bus.m1_read = 1; bus.m1_address = ad[i]; end
      #1;
      checks++;
      if ((who[i] == 0 ? bus.m0_waitrequest : bus.m1_waitrequest) !== 1'b0) begin
        errors++; $display("FAIL il_grant %0d: waitrequest=1 want 0", i);
      end
    end
    @(negedge clk);
    idle();
    checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 20'h3) begin
      errors++; $display("FAIL il_fwd: s_read=%b addr=%h want 1 00003", bus.s_read, bus.s_address);
    end
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        got = (who[i-1] == 0) ? bus.m0_readdata : bus.m1_readdata;
        checks++;
        if (bus.m0_readdatavalid !== (who[i-1] == 0) || bus.m1_readdatavalid !== (who[i-1] == 1) || got !== dv[i-1]) begin
          errors++; $display("FAIL il_rsp %0d: rdv=%b/%b data=%h want master %0d data %h",
                             i-1, bus.m0_readdatavalid, bus.m1_readdatavalid, got, who[i-1], dv[i-1]);
        end
      end
      idle();
      if (i < 3) begin bus.s_readdatavalid = 1; bus.s_readdata = dv[i]; end
    end
    @(negedge clk);
    checks++;
    if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL il_quiet: rdv=%b/%b want 0/0", bus.m0_readdatavalid, bus.m1_readdatavalid);
    end
  endtask

  task automatic test_fifo_full();
    int cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      bus.m0_read = 1; bus.m0_address = 20'h100 + 20'(i);
      #1;
      checks++;
      if (bus.m0_waitrequest !== 1'b0) begin
        errors++; $display("FAIL ff_fill %0d: m0_waitrequest=1 want 0", i);
      end
    end
    @(negedge clk);
    idle();
    bus.m0_read = 1; bus.m0_address = 20'h104;
    bus.m1_write = 1; bus.m1_address = 20'h200; bus.m1_writedata = 16'h5555; bus.m1_byteenable = 2'b01;
    #1;
    checks++;
    if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL ff_block: wait=%b/%b want 1/0", bus.m0_waitrequest, bus.m1_waitrequest);
    end
    @(negedge clk);
    checks++;
    if (bus.s_write !== 1'b1 || bus.s_address !== 20'h200 || bus.s_writedata !== 16'h5555) begin
      errors++; $display("FAIL ff_m1wr: wr=%b addr=%h data=%h want 1 00200 5555", bus.s_write, bus.s_address, bus.s_writedata);
    end
    bus.m1_write = 0;
    bus.s_readdatavalid = 1; bus.s_readdata = 16'hAAAA;
    #1;
    checks++;
    if (bus.m0_waitrequest !== 1'b1) begin
      errors++; $display("FAIL ff_popcycle: m0_waitrequest=%b want 1", bus.m0_waitrequest);
    end
    @(negedge clk);
    bus.s_readdatavalid = 0;
    checks++;
    if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 16'hAAAA) begin
      errors++; $display("FAIL ff_rsp: rdv=%b data=%h want 1 aaaa", bus.m0_readdatavalid, bus.m0_readdata);
    end
    #1;
    checks++;
    if (bus.m0_waitrequest !== 1'b0) begin
      errors++; $display("FAIL ff_unblock: m0_waitrequest=%b want 0", bus.m0_waitrequest);
    end
    @(negedge clk);
    idle();
    checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 20'h104) begin
      errors++; $display("FAIL ff_fwd: s_read=%b addr=%h want 1 00104", bus.s_read, bus.s_address);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (bus.m0_readdatavalid === 1'b1) cnt++;
      bus.s_readdatavalid = (j < 4);
      bus.s_readdata = 16'h0B00 + 16'(j);
    end
    idle();
    checks++;
    if (cnt != 4 || rd_err !== 1'b0) begin
      errors++; $display("FAIL ff_drain: responses=%0d rd_err=%b want 4 0", cnt, rd_err);
    end
  endtask

  task automatic run_traffic(input int ncyc, input bit both_read, input string tag);
    int          pend [$];
    logic [15:0] ctl [$];
    int          last_g, win, exp_rdv;
    bit          full, ret;
    bit          exp_v, exp_rd, exp_wr;
    logic [19:0] exp_a;
    logic [1:0]  exp_be;
    logic [15:0] exp_wd, exp_rdata, ret_d, got;
    bit          act [2], rd [2], wr [2], stall [2], el [2];
    logic [19:0] ad [2];
    logic [15:0] wd [2];
    logic [1:0]  be [2];
    int          nacc [2], nrdv [2];
    logic        wreq;
    apply_reset();
    last_g = 1; exp_v = 0; exp_rd = 0; exp_wr = 0; exp_rdv = -1;
    exp_a = '0; exp_be = '0; exp_wd = '0; exp_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; rd[m] = 0; wr[m] = 0; stall[m] = 0; nacc[m] = 0; nrdv[m] = 0;
      ad[m] = '0; wd[m] = '0; be[m] = '0;
    end
    for (int c = 0; c < ncyc + 24; c++) begin
      @(negedge clk);
      checks++;
      if (bus.s_read !== (exp_v && exp_rd) || bus.s_write !== (exp_v && exp_wr)) begin
        errors++; $display("FAIL %s strobe cyc %0d: rd=%b wr=%b want %b %b", tag, c, bus.s_read, bus.s_write,
                           exp_v && exp_rd, exp_v && exp_wr);
      end
      if (exp_v) begin
        checks++;
        if (bus.s_address !== exp_a || bus.s_byteenable !== exp_be || (exp_wr && bus.s_writedata !== exp_wd)) begin
          errors++; $display("FAIL %s cmd cyc %0d: addr=%h be=%b data=%h want %h %b %h", tag, c,
                             bus.s_address, bus.s_byteenable, bus.s_writedata, exp_a, exp_be, exp_wd);
        end
      end
      checks++;
      if (bus.m0_readdatavalid !== (exp_rdv == 0) || bus.m1_readdatavalid !== (exp_rdv == 1)) begin
        errors++; $display("FAIL %s rdv cyc %0d: got %b/%b want owner %0d", tag, c,
                           bus.m0_readdatavalid, bus.m1_readdatavalid, exp_rdv);
      end
      if (exp_rdv >= 0) begin
        got = (exp_rdv == 1) ? bus.m1_readdata : bus.m0_readdata;
        checks++;
        if (got !== exp_rdata) begin
          errors++; $display("FAIL %s rdata cyc %0d: got %h want %h", tag, c, got, exp_rdata);
        end
      end
      if (bus.m0_readdatavalid === 1'b1) nrdv[0]++;
      if (bus.m1_readdatavalid === 1'b1) nrdv[1]++;
      // controller: return oldest visible read, then note the read now on the bus
      ret = (ctl.size() > 0) && (both_read || c >= ncyc || $urandom_range(0, 1) == 1);
      ret_d = ret ? ctl.pop_front() : 16'($urandom);
      if (exp_v && exp_rd) ctl.push_back(exp_a[15:0] ^ 16'hA5C3);
      for (int m = 0; m < 2; m++) begin
        if (!stall[m]) begin
          if (c >= ncyc) begin
            act[m] = 0; rd[m] = 0; wr[m] = 0;
          end else if (both_read) begin
            act[m] = 1; rd[m] = 1; wr[m] = 0;
          end else begin
            act[m] = ($urandom_range(0, 3) != 0);
            rd[m]  = ($urandom_range(0, 1) == 1);
            wr[m]  = !rd[m] || ($urandom_range(0, 3) == 0);
          end
          ad[m] = 20'($urandom); wd[m] = 16'($urandom); be[m] = 2'($urandom);
        end
      end
      bus.m0_read = act[0] && rd[0]; bus.m0_write = act[0] && wr[0];
      bus.m0_address = ad[0]; bus.m0_writedata = wd[0]; bus.m0_byteenable = be[0];
      bus.m1_read = act[1] && rd[1]; bus.m1_write = act[1] && wr[1];
      bus.m1_address = ad[1]; bus.m1_writedata = wd[1]; bus.m1_byteenable = be[1];
      bus.s_readdatavalid = ret; bus.s_readdata = ret_d;
      #1;
      full = (pend.size() == MAXP);
      for (int m = 0; m < 2; m++) el[m] = act[m] && !(rd[m] && !wr[m] && full);
      if (el[0] && el[1]) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        win = 0;
`else
        win = (last_g == 0) ? 1 : 0;
`endif
      end else begin
        win = el[0] ? 0 : (el[1] ? 1 : -1);
      end
      for (int m = 0; m < 2; m++) begin
        if (act[m]) begin
          wreq = (m == 0) ? bus.m0_waitrequest : bus.m1_waitrequest;
          checks++;
          if (wreq !== (win != m)) begin
            errors++; $display("FAIL %s wait m%0d cyc %0d: got %b want %b", tag, m, c, wreq, win != m);
          end
        end
        stall[m] = act[m] && (win != m);
      end
      exp_rdv = -1;
      if (ret) begin
        exp_rdata = ret_d;
        if (pend.size() > 0) exp_rdv = pend.pop_front();
      end
      exp_v = (win >= 0);
      if (exp_v) begin
        last_g = win;
        exp_wr = wr[win]; exp_rd = rd[win] && !wr[win];
        exp_a = ad[win]; exp_be = be[win]; exp_wd = wd[win];
        if (exp_rd) begin pend.push_back(win); nacc[win]++; end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (nrdv[m] != nacc[m]) begin
        errors++; $display("FAIL %s count m%0d: responses %0d want %0d", tag, m, nrdv[m], nacc[m]);
      end
    end
    idle();
  endtask

  task automatic test_round_robin();
    run_traffic(20, 1'b1, "rr");
  endtask

  task automatic test_random();
    run_traffic(400, 1'b0, "rand");
  endtask

  task automatic test_rd_err();
    @(negedge clk);
    idle();
    bus.s_readdatavalid = 1; bus.s_readdata = 16'hDEAD;
    @(negedge clk);
    idle();
    checks++;
    if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0 || rd_err !== 1'b1) begin
      errors++; $display("FAIL rderr_set: rdv=%b/%b rd_err=%b want 0/0 1", bus.m0_readdatavalid, bus.m1_readdatavalid, rd_err);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rd_err !== 1'b1) begin
      errors++; $display("FAIL rderr_sticky: rd_err=%b want 1", rd_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      if (i == 1) begin bus.m1_read = 1; bus.m1_address = 20'h40 + 20'(i); end
      else        begin bus.m0_read = 1; bus.m0_address = 20'h40 + 20'(i); end
    end
    @(negedge clk);
    idle();
    bus.m0_read = 1;
    reset_n = 0;
    #1;
    checks++;
    if (bus.m0_waitrequest !== 1'b1 || bus.m1_waitrequest !== 1'b1 || bus.s_read !== 1'b0 || bus.s_write !== 1'b0) begin
      errors++; $display("FAIL rmid_out: wait=%b/%b s_rd=%b s_wr=%b want 1/1 0 0",
                         bus.m0_waitrequest, bus.m1_waitrequest, bus.s_read, bus.s_write);
    end
    checks++;
    if (rd_err !== 1'b0 || bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rmid_flags: rd_err=%b rdv=%b/%b want 0 0/0", rd_err, bus.m0_readdatavalid, bus.m1_readdatavalid);
    end
    @(negedge clk);
    idle();
    reset_n = 1;
    bus.m1_read = 1; bus.m1_address = 20'h77;
    #1;
    checks++;
    if (bus.m1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL rmid_accept: m1_waitrequest=%b want 0", bus.m1_waitrequest);
    end
    @(negedge clk);
    idle();
    checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 20'h77) begin
      errors++; $display("FAIL rmid_fwd: s_read=%b addr=%h want 1 00077", bus.s_read, bus.s_address);
    end
    bus.s_readdatavalid = 1; bus.s_readdata = 16'h7777;
    @(negedge clk);
    checks++;
    if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 16'h7777 || bus.m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rmid_rsp: rdv=%b/%b data=%h want 0/1 7777",
                         bus.m0_readdatavalid, bus.m1_readdatavalid, bus.m1_readdata);
    end
    bus.s_readdata = 16'h8888;
    @(negedge clk);
    idle();
    checks++;
    if (bus.m0_readdatavalid !== 1'b0 || bus.m1_readdatavalid !== 1'b0 || rd_err !== 1'b1) begin
      errors++; $display("FAIL rmid_empty: rdv=%b/%b rd_err=%b want 0/0 1",
                         bus.m0_readdatavalid, bus.m1_readdatavalid, rd_err);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_write();
    test_interleave();
    test_fifo_full();
    test_round_robin();
    test_random();
    test_rd_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
